// File: rtl/start_sequencer.sv
// Power-on start sequencer: after reset, waits a DIP-selected delay of
//   (sel+1)*BASE_SEC seconds, then releases N_CH sticky start enables one by
//   one, CH_GAP_MS apart, and flags completion.
// Ports: i_clk_50M / i_rst_n (sync, active-low) clock and reset; i_dip is the
//   active-low async DIP select; i_hold freezes timing in DELAY/STAGGER;
//   i_restart reruns the sequence; o_start per-channel enables; o_busy in
//   DELAY/STAGGER; o_done in DONE; o_remain_sec whole seconds left in DELAY.
module start_sequencer #(
  parameter int CLK_HZ    = 50000000,
  parameter int SEL_W     = 2,
  parameter int BASE_SEC  = 15,
  parameter int N_CH      = 4,
  parameter int CH_GAP_MS = 100
) (
  input  logic             i_clk_50M,
  input  logic             i_rst_n,
  input  logic [SEL_W-1:0] i_dip,
  input  logic             i_hold,
  input  logic             i_restart,
  output logic [N_CH-1:0]  o_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_remain_sec
);

  localparam int PRESC = CLK_HZ / 1000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int GAP   = CH_GAP_MS * PRESC;
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_STAGGER = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idle_cnt_q, idle_cnt_d;
  logic [SEL_W-1:0]  sync1_q, sync1_d;
  logic [SEL_W-1:0]  sync2_q, sync2_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [9:0]        ms_q, ms_d;
  logic [15:0]       sec_q, sec_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [N_CH-1:0]   start_q, start_d;
  logic [SEL_W-1:0]  sel;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    sync1_d    = i_dip;
    sync2_d    = sync1_q;
    presc_d    = presc_q;
    ms_d       = ms_q;
    sec_d      = sec_q;
    gap_d      = gap_q;
    ch_d       = ch_q;
    start_d    = start_q;
    sel        = ~sync2_q;

    if (i_restart) begin
      // Restart beats hold: everything returns to the start of IDLE.
      state_d    = S_IDLE;
      idle_cnt_d = 2'd0;
      presc_d    = '0;
      ms_d       = '0;
      sec_d      = '0;
      gap_d      = '0;
      ch_d       = '0;
      start_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Third edge: the synchroniser now holds a DIP value sampled
          // after reset, so the selection is latched here and only here.
          if (idle_cnt_q == 2'd2) begin
            state_d = S_DELAY;
            sec_d   = 16'((int'(sel) + 1) * BASE_SEC);
            presc_d = '0;
            ms_d    = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 2'd1;
          end
        end
        S_DELAY: begin
          if (!i_hold) begin
            if (presc_q == PW'(PRESC - 1)) begin
              presc_d = '0;
              if (ms_q == 10'd999) begin
                ms_d  = '0;
                sec_d = sec_q - 16'd1;
                if (sec_q == 16'd1) begin
                  start_d[0] = 1'b1;
                  gap_d      = '0;
                  ch_d       = CW'(1);
                  state_d    = (N_CH == 1) ? S_DONE : S_STAGGER;
                end
              end else begin
                ms_d = ms_q + 10'd1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        S_STAGGER: begin
          if (!i_hold) begin
            if (gap_q == GW'(GAP - 1)) begin
              gap_d = '0;
              for (int i = 1; i < N_CH; i++) begin
                if (int'(ch_q) == i) start_d[i] = 1'b1;
              end
              if (int'(ch_q) == N_CH - 1) state_d = S_DONE;
              else                        ch_d    = ch_q + CW'(1);
            end else begin
              gap_d = gap_q + GW'(1);
            end
          end
        end
        default: ; // DONE holds its outputs
      endcase
    end
  end

  always_ff @(posedge i_clk_50M) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      ms_q       <= '0;
      sec_q      <= '0;
      gap_q      <= '0;
      ch_q       <= '0;
      start_q    <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      sec_q      <= sec_d;
      gap_q      <= gap_d;
      ch_q       <= ch_d;
      start_q    <= start_d;
    end
  end

  assign o_start      = start_q;
  assign o_busy       = (state_q == S_DELAY) || (state_q == S_STAGGER);
  assign o_done       = (state_q == S_DONE);
  assign o_remain_sec = sec_q;

endmodule

// File: tb/tb_start_sequencer.sv
module tb_start_sequencer;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [1:0]  i_dip;
  logic        i_hold;
  logic        i_restart;
  logic [3:0]  o_start;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_remain_sec;

  always #5 clk = ~clk;

  start_sequencer #(
    .CLK_HZ(8000), .SEL_W(2), .BASE_SEC(1), .N_CH(4), .CH_GAP_MS(2)
  ) dut (
    .i_clk_50M   (clk),
    .i_rst_n     (i_rst_n),
    .i_dip       (i_dip),
    .i_hold      (i_hold),
    .i_restart   (i_restart),
    .o_start     (o_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_remain_sec(o_remain_sec)
  );

  typedef struct {
    string      name;
    logic [1:0] dip;
    int         dchg_at;
    logic [1:0] dchg_val;
    int         ha_s, ha_n, hb_s, hb_n;
    int         r1_e, r1_v, r2_e, r2_v;
    int         e0, e1, e2, e3;
    int         stop;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int ecount;
  int rise[4];
  int done_e;
  int busy_at_done;

  // Event schedule, in edge numbers since the last reset release.
  int         ha_s, ha_n, hb_s, hb_n;
  int         dchg_at;
  logic [1:0] dchg_val;
  int         rs1, rs2, rst_at;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_rises();
    for (int k = 0; k < 4; k++) rise[k] = -1;
    done_e       = -1;
    busy_at_done = -1;
  endtask

  task automatic do_reset(input logic [1:0] dip);
    i_rst_n   = 1'b0;
    i_hold    = 1'b0;
    i_restart = 1'b0;
    i_dip     = dip;
    ha_s = -1; ha_n = 0; hb_s = -1; hb_n = 0;
    dchg_at = -1; dchg_val = 2'b00;
    rs1 = -1; rs2 = -1; rst_at = -1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_start", int'(o_start), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_remain", int'(o_remain_sec), 0);
    i_rst_n = 1'b1;
    ecount  = 0;
    clear_rises();
  endtask

  // Drive the inputs for the next edge, take it, then sample just after.
  task automatic tick();
    int e;
    e = ecount + 1;
    i_hold = ((ha_s >= 0) && (e >= ha_s) && (e < ha_s + ha_n)) ||
             ((hb_s >= 0) && (e >= hb_s) && (e < hb_s + hb_n)) ||
             (e == rs2);
    i_restart = (e == rs1) || (e == rs2);
    i_rst_n   = (e != rst_at);
    if ((dchg_at >= 0) && (e >= dchg_at)) i_dip = dchg_val;
    @(posedge clk);
    #1;
    ecount = e;
    for (int k = 0; k < 4; k++)
      if (o_start[k] && rise[k] < 0) rise[k] = e;
    if (o_done && done_e < 0) begin
      done_e       = e;
      busy_at_done = int'(o_busy);
    end
  endtask

  task automatic run_to(input int e_stop);
    while (ecount < e_stop) tick();
  endtask

  task automatic run_vec(input vec_t v);
    do_reset(v.dip);
    ha_s = v.ha_s; ha_n = v.ha_n; hb_s = v.hb_s; hb_n = v.hb_n;
    dchg_at = v.dchg_at; dchg_val = v.dchg_val;
    while (ecount < v.stop) begin
      tick();
      if (ecount == 2) check({v.name, "_busy_e2"}, int'(o_busy), 0);
      if (ecount == 3) check({v.name, "_busy_e3"}, int'(o_busy), 1);
      if (ecount == v.r1_e) check({v.name, "_remain1"}, int'(o_remain_sec), v.r1_v);
      if (ecount == v.r2_e) check({v.name, "_remain2"}, int'(o_remain_sec), v.r2_v);
    end
    check({v.name, "_start0"}, rise[0], v.e0);
    if (v.e1 >= 0) check({v.name, "_start1"}, rise[1], v.e1);
    if (v.e2 >= 0) check({v.name, "_start2"}, rise[2], v.e2);
    if (v.e3 >= 0) begin
      check({v.name, "_start3"}, rise[3], v.e3);
      check({v.name, "_done_edge"}, done_e, v.e3);
      check({v.name, "_busy_at_done"}, busy_at_done, 0);
    end
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{"sel0_latch", 2'b11, 100, 2'b00, -1, 0, -1, 0,
               3, 1, 8003, 0, 8003, 8019, 8035, 8051, 8051};
    tbl[1] = '{"sel3", 2'b00, -1, 2'b00, -1, 0, -1, 0,
               3, 4, 8003, 3, 32003, -1, -1, -1, 32003};
    tbl[2] = '{"hold", 2'b11, -1, 2'b00, 1000, 50, 8060, 10,
               3, 1, 8052, 1, 8053, 8079, 8095, 8111, 8111};

    for (int i = 0; i < 3; i++) run_vec(tbl[i]);

    // Restart from DONE reruns the whole sequence from the restart edge.
    do_reset(2'b11);
    rs1 = 9000;
    run_to(9000);
    check("rst_done_start3_before", rise[3], 8051);
    check("restart_start", int'(o_start), 0);
    check("restart_busy", int'(o_busy), 0);
    check("restart_done", int'(o_done), 0);
    check("restart_remain", int'(o_remain_sec), 0);
    clear_rises();
    run_to(17003);
    check("restart_start0", rise[0], 17003);

    // Reset mid-STAGGER, then restart together with hold during DELAY.
    do_reset(2'b11);
    rst_at = 8020;
    rs2    = 8030;
    run_to(8020);
    check("midrst_start1_before", rise[1], 8019);
    check("midrst_start", int'(o_start), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_done", int'(o_done), 0);
    clear_rises();
    run_to(8022);
    check("midrst_busy_idle", int'(o_busy), 0);
    tick();
    check("midrst_busy_e3", int'(o_busy), 1);
    check("midrst_remain_e3", int'(o_remain_sec), 1);
    run_to(8030);
    check("rsthold_start", int'(o_start), 0);
    check("rsthold_busy", int'(o_busy), 0);
    check("rsthold_remain", int'(o_remain_sec), 0);
    clear_rises();
    run_to(16081);
    check("rsthold_start0", rise[0], 16033);
    check("rsthold_start3", rise[3], 16081);
    check("rsthold_done_edge", done_e, 16081);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
